// File: rtl/ras_ckpt.sv
// Return address stack for fetch prediction: circular buffer of return targets with (index,count) checkpoint/restore.
// Latency: ret_target/ret_valid/checkpoint/overflow/underflow are combinational from current state; updates land on the next CLK edge.
// Backpressure: none; every push/pop/restore is accepted each cycle (full overwrites oldest, empty pop is a no-op). Optional macro RAS_STAT_EN adds event counters.
module ras_ckpt #(
   parameter int RAS_ENTRIES      = 8,
   parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
   parameter int RAS_TARGET_WIDTH = 31,
   parameter int STAT_WIDTH       = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        push_valid,
   input  logic [RAS_TARGET_WIDTH-1:0] push_target,
   input  logic                        pop_valid,
   output logic                        ret_valid,
   output logic [RAS_TARGET_WIDTH-1:0] ret_target,
   output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
   output logic [RAS_INDEX_WIDTH:0]    ras_count,
   input  logic                        restore_valid,
   input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
   input  logic [RAS_INDEX_WIDTH:0]    restore_count,
   output logic                        overflow,
   output logic                        underflow
`ifdef RAS_STAT_EN
   ,
   output logic [STAT_WIDTH-1:0]       stat_overflow_cnt,
   output logic [STAT_WIDTH-1:0]       stat_underflow_cnt
`endif
);

   // Occupancy value meaning "every slot holds a live return address".
   localparam logic [RAS_INDEX_WIDTH:0] LP_FULL = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);

   // Stack storage and checkpointable state.
   logic [RAS_TARGET_WIDTH-1:0] r_entry [RAS_ENTRIES];
   logic [RAS_INDEX_WIDTH-1:0]  r_ptr;
   logic [RAS_INDEX_WIDTH:0]    r_count;

   // Decoded operation for this cycle; restore suppresses push/pop entirely.
   logic                        w_empty;
   logic                        w_full;
   logic                        w_push_only;
   logic                        w_pop_only;
   logic                        w_push_pop;
   logic [RAS_INDEX_WIDTH-1:0]  w_ptr_inc;
   logic [RAS_INDEX_WIDTH-1:0]  w_ptr_dec;
   logic [RAS_INDEX_WIDTH:0]    w_restore_cnt;

   // Operation decode and pointer arithmetic (pointers wrap naturally at RAS_INDEX_WIDTH bits).
   always_comb begin
      w_empty       = (r_count == '0);
      w_full        = (r_count == LP_FULL);
      w_push_only   = push_valid & ~pop_valid & ~restore_valid;
      w_pop_only    = pop_valid & ~push_valid & ~restore_valid;
      w_push_pop    = push_valid & pop_valid & ~restore_valid;
      w_ptr_inc     = r_ptr + RAS_INDEX_WIDTH'(1);
      w_ptr_dec     = r_ptr - RAS_INDEX_WIDTH'(1);
      // A restored occupancy can never exceed the physical depth.
      w_restore_cnt = (restore_count > LP_FULL) ? LP_FULL : restore_count;
   end

   // Outputs are pure functions of pre-edge state plus this cycle's requests.
   always_comb begin
      ret_valid  = ~w_empty;
      ret_target = r_entry[r_ptr];
      ras_index  = r_ptr;
      ras_count  = r_count;
      overflow   = w_push_only & w_full;
      underflow  = w_pop_only & w_empty;
   end

   // Pointer and occupancy update: reset, then restore, then push/pop.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (restore_valid) begin
         r_ptr   <= restore_index;
         r_count <= w_restore_cnt;
      end else if (w_push_pop) begin
         // Call-and-return replaces the top in place; an empty stack gains one entry.
         if (w_empty) begin
            r_count <= (RAS_INDEX_WIDTH+1)'(1);
         end
      end else if (w_push_only) begin
         r_ptr <= w_ptr_inc;
         // When full, the oldest slot is silently reused and occupancy stays at depth.
         if (!w_full) begin
            r_count <= r_count + (RAS_INDEX_WIDTH+1)'(1);
         end
      end else if (w_pop_only && !w_empty) begin
         r_ptr   <= w_ptr_dec;
         r_count <= r_count - (RAS_INDEX_WIDTH+1)'(1);
      end
   end

   // Entry writes; pops and restores leave contents alone so stale data can be re-exposed by a restore.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < RAS_ENTRIES; i++) begin
            r_entry[i] <= '0;
         end
      end else if (w_push_pop) begin
         r_entry[r_ptr] <= push_target;
      end else if (w_push_only) begin
         r_entry[w_ptr_inc] <= push_target;
      end
   end

`ifdef RAS_STAT_EN
   logic [STAT_WIDTH-1:0] r_ovf_cnt;
   logic [STAT_WIDTH-1:0] r_unf_cnt;

   // Saturating counts of cycles flagged overflow/underflow.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ovf_cnt <= '0;
         r_unf_cnt <= '0;
      end else begin
         if (overflow && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + STAT_WIDTH'(1);
         end
         if (underflow && (r_unf_cnt != '1)) begin
            r_unf_cnt <= r_unf_cnt + STAT_WIDTH'(1);
         end
      end
   end

   // Counter export.
   always_comb begin
      stat_overflow_cnt  = r_ovf_cnt;
      stat_underflow_cnt = r_unf_cnt;
   end
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: per-scenario tasks with a scoreboard of post-edge expected state.
// Inputs change on the falling edge; combinational flags are sampled 1ns later, state 1ns after the rising edge.
// Runs against the default build; the event-counter scenario is compiled only with RAS_STAT_EN.
module tb_ras_ckpt;

   typedef struct packed {
      logic        vld;
      logic [30:0] tgt;
      logic [2:0]  idx;
      logic [3:0]  cnt;
   } obs_t;

   typedef struct packed {
      logic        rst;
      logic        push;
      logic [30:0] tgt;
      logic        pop;
      logic        rv;
      logic [2:0]  ri;
      logic [3:0]  rc;
      logic        ovf;
      logic        unf;
      logic        chk_pre;
      logic [30:0] pre_tgt;
      obs_t        post;
   } step_t;

   logic        CLK;
   logic        RST;
   logic        push_valid;
   logic [30:0] push_target;
   logic        pop_valid;
   logic        ret_valid;
   logic [30:0] ret_target;
   logic [2:0]  ras_index;
   logic [3:0]  ras_count;
   logic        restore_valid;
   logic [2:0]  restore_index;
   logic [3:0]  restore_count;
   logic        overflow;
   logic        underflow;
`ifdef RAS_STAT_EN
   logic [15:0] stat_overflow_cnt;
   logic [15:0] stat_underflow_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   step_t sq[$];
   obs_t  exp_q[$];

   ras_ckpt dut (
      .CLK(CLK), .RST(RST),
      .push_valid(push_valid), .push_target(push_target), .pop_valid(pop_valid),
      .ret_valid(ret_valid), .ret_target(ret_target),
      .ras_index(ras_index), .ras_count(ras_count),
      .restore_valid(restore_valid), .restore_index(restore_index), .restore_count(restore_count),
      .overflow(overflow), .underflow(underflow)
`ifdef RAS_STAT_EN
      , .stat_overflow_cnt(stat_overflow_cnt), .stat_underflow_cnt(stat_underflow_cnt)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic obs_t cur();
      return '{vld: ret_valid, tgt: ret_target, idx: ras_index, cnt: ras_count};
   endfunction

   function automatic obs_t ob(input logic v, input int t, input int i, input int c);
      return '{vld: v, tgt: 31'(t), idx: 3'(i), cnt: 4'(c)};
   endfunction

   // Queue one cycle of stimulus with its expected flags and post-edge state.
   function automatic void add(input logic rst, input logic push, input int tgt, input logic pop,
                               input logic rv, input int ri, input int rc,
                               input logic ovf, input logic unf, input logic chk, input int pre,
                               input obs_t post);
      step_t s;
      s.rst = rst; s.push = push; s.tgt = 31'(tgt); s.pop = pop;
      s.rv = rv; s.ri = 3'(ri); s.rc = 4'(rc);
      s.ovf = ovf; s.unf = unf; s.chk_pre = chk; s.pre_tgt = 31'(pre); s.post = post;
      sq.push_back(s);
   endfunction

   task automatic apply(input step_t s);
      RST = s.rst; push_valid = s.push; push_target = s.tgt; pop_valid = s.pop;
      restore_valid = s.rv; restore_index = s.ri; restore_count = s.rc;
   endtask

   task automatic idle();
      @(negedge CLK);
      RST = 1'b0; push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
      push_target = '0; restore_index = '0; restore_count = '0;
   endtask

   task automatic test_reset();
      step_t s; obs_t e;
      add(1, 1, 'h55, 0, 0, 0, 0, 0, 0, 0, 0, ob(0, 0, 0, 0));
      add(1, 0, 0, 1, 1, 5, 5, 0, 0, 0, 0, ob(0, 0, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         @(negedge CLK); apply(s); exp_q.push_back(s.post);
         @(posedge CLK); #1;
         e = exp_q.pop_front();
         n_tests++;
         if (cur() !== e) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", cur(), e); end
      end
      idle(); #1;
      n_tests++;
      if ({overflow, underflow} !== 2'b00) begin
         n_fail++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow});
      end
   endtask

   task automatic test_push_pop();
      step_t s; obs_t e;
      add(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h100, 1, 1));
      add(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h200, 2, 2));
      add(0, 1, 'h300, 0, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h300, 3, 3));
      add(0, 0, 0,     1, 0, 0, 0, 0, 0, 1, 'h300, ob(1, 'h200, 2, 2));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         @(negedge CLK); apply(s); exp_q.push_back(s.post); #1;
         n_tests++;
         if ({overflow, underflow} !== {s.ovf, s.unf}) begin
            n_fail++; $display("FAIL push_pop_flags got=%b exp=%b", {overflow, underflow}, {s.ovf, s.unf});
         end
         if (s.chk_pre) begin
            n_tests++;
            if (ret_target !== s.pre_tgt) begin
               n_fail++; $display("FAIL push_pop_pop_target got=%h exp=%h", ret_target, s.pre_tgt);
            end
         end
         @(posedge CLK); #1;
         e = exp_q.pop_front();
         n_tests++;
         if (cur() !== e) begin n_fail++; $display("FAIL push_pop_state got=%h exp=%h", cur(), e); end
      end
      idle();
   endtask

   task automatic test_back_to_back();
      step_t s; obs_t e;
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ob(0, 0, 0, 0));
      for (int k = 1; k <= 9; k++) begin
         add(0, 1, k, 0, 0, 0, 0, (k == 9), 0, 0, 0, ob(1, k, k % 8, (k > 8) ? 8 : k));
      end
      for (int j = 1; j <= 8; j++) begin
         add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 10 - j,
             ob(j != 8, (j == 8) ? 9 : 9 - j, (1 - j) & 7, 8 - j));
      end
      add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, ob(0, 9, 1, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         @(negedge CLK); apply(s); exp_q.push_back(s.post); #1;
         if (!s.rst) begin
            n_tests++;
            if ({overflow, underflow} !== {s.ovf, s.unf}) begin
               n_fail++; $display("FAIL b2b_flags got=%b exp=%b tgt=%h", {overflow, underflow}, {s.ovf, s.unf}, s.tgt);
            end
         end
         if (s.chk_pre) begin
            n_tests++;
            if (ret_target !== s.pre_tgt) begin
               n_fail++; $display("FAIL b2b_pop_target got=%h exp=%h", ret_target, s.pre_tgt);
            end
         end
         @(posedge CLK); #1;
         e = exp_q.pop_front();
         n_tests++;
         if (cur() !== e) begin n_fail++; $display("FAIL b2b_state got=%h exp=%h", cur(), e); end
      end
      idle();
   endtask

   task automatic test_call_return();
      step_t s; obs_t e;
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ob(0, 0, 0, 0));
      add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, ob(1, 0, 0, 1));
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ob(0, 0, 0, 0));
      add(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h100, 1, 1));
      add(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h200, 2, 2));
      add(0, 1, 'h500, 1, 0, 0, 0, 0, 0, 1, 'h200, ob(1, 'h500, 2, 2));
      add(0, 0, 0,     1, 0, 0, 0, 0, 0, 1, 'h500, ob(1, 'h100, 1, 1));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         @(negedge CLK); apply(s); exp_q.push_back(s.post); #1;
         if (!s.rst) begin
            n_tests++;
            if ({overflow, underflow} !== {s.ovf, s.unf}) begin
               n_fail++; $display("FAIL callret_flags got=%b exp=%b", {overflow, underflow}, {s.ovf, s.unf});
            end
         end
         if (s.chk_pre) begin
            n_tests++;
            if (ret_target !== s.pre_tgt) begin
               n_fail++; $display("FAIL callret_pre_target got=%h exp=%h", ret_target, s.pre_tgt);
            end
         end
         @(posedge CLK); #1;
         e = exp_q.pop_front();
         n_tests++;
         if (cur() !== e) begin n_fail++; $display("FAIL callret_state got=%h exp=%h", cur(), e); end
      end
      idle();
   endtask

   task automatic test_restore();
      step_t s; obs_t e;
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ob(0, 0, 0, 0));
      add(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h100, 1, 1));
      add(0, 1, 'h200, 0, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h200, 2, 2));
      add(0, 1, 'h700, 0, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h700, 3, 3));
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h200, 2, 2));
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h100, 1, 1));
      add(0, 1, 'h999, 0, 1, 2, 2, 0, 0, 0, 0, ob(1, 'h200, 2, 2));
      add(0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0, ob(1, 'h700, 3, 1));
      add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ob(0, 0, 0, 0));
      add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, ob(0, 0, 0, 0));
      for (int k = 1; k <= 7; k++) begin
         add(0, 1, 'h10 + k, 0, 0, 0, 0, 0, 0, 0, 0, ob(1, 'h10 + k, k, k));
      end
      add(0, 1, 'hAAA, 0, 0, 0, 0, 0, 0, 0, 0, ob(1, 'hAAA, 0, 8));
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'hAAA, ob(1, 'h17, 7, 7));
      add(0, 0, 0, 0, 1, 7, 15, 0, 0, 0, 0, ob(1, 'h17, 7, 8));
      add(0, 1, 'h123, 0, 1, 7, 8, 0, 0, 0, 0, ob(1, 'h17, 7, 8));
      add(1, 1, 'h321, 1, 1, 4, 4, 0, 0, 0, 0, ob(0, 0, 0, 0));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         @(negedge CLK); apply(s); exp_q.push_back(s.post); #1;
         if (!s.rst) begin
            n_tests++;
            if ({overflow, underflow} !== {s.ovf, s.unf}) begin
               n_fail++; $display("FAIL restore_flags got=%b exp=%b", {overflow, underflow}, {s.ovf, s.unf});
            end
         end
         if (s.chk_pre) begin
            n_tests++;
            if (ret_target !== s.pre_tgt) begin
               n_fail++; $display("FAIL restore_pre_target got=%h exp=%h", ret_target, s.pre_tgt);
            end
         end
         @(posedge CLK); #1;
         e = exp_q.pop_front();
         n_tests++;
         if (cur() !== e) begin n_fail++; $display("FAIL restore_state got=%h exp=%h", cur(), e); end
      end
      idle();
   endtask

`ifdef RAS_STAT_EN
   task automatic test_stats();
      step_t s;
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ob(0, 0, 0, 0));
      for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, ob(0, 0, 0, 0));
      for (int k = 1; k <= 10; k++) add(0, 1, k, 0, 0, 0, 0, (k > 8), 0, 0, 0, ob(1, k, k % 8, (k > 8) ? 8 : k));
      while (sq.size() > 0) begin
         s = sq.pop_front();
         @(negedge CLK); apply(s); exp_q.push_back(s.post);
         @(posedge CLK); #1;
         void'(exp_q.pop_front());
      end
      n_tests++;
      if (stat_underflow_cnt !== 16'd3) begin
         n_fail++; $display("FAIL stat_underflow got=%0d exp=3", stat_underflow_cnt);
      end
      n_tests++;
      if (stat_overflow_cnt !== 16'd2) begin
         n_fail++; $display("FAIL stat_overflow got=%0d exp=2", stat_overflow_cnt);
      end
      @(negedge CLK); RST = 1'b1; push_valid = 1'b1; push_target = 31'h44;
      @(posedge CLK); #1;
      n_tests++;
      if ({cur(), stat_overflow_cnt, stat_underflow_cnt} !== '0) begin
         n_fail++; $display("FAIL stat_reset got=%h/%0d/%0d exp=0", cur(), stat_overflow_cnt, stat_underflow_cnt);
      end
      idle();
   endtask
`endif

   initial begin
      RST = 1'b1; push_valid = 1'b0; push_target = '0; pop_valid = 1'b0;
      restore_valid = 1'b0; restore_index = '0; restore_count = '0;
      test_reset();
      test_push_pop();
      test_back_to_back();
      test_call_return();
      test_restore();
`ifdef RAS_STAT_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
